// File: rtl/spram_ctrl.sv
// Word-wide (32-bit) request/response front end for a 16K x 16 single-port RAM.
// Each word is transferred as two halfwords, high half first, at halfwords {addr,0} and {addr,1}.
module spram_ctrl #(
  parameter int unsigned AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [3:0]    req_be,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic [AW:0]   mem_addr,
  output logic [3:0]    mem_we,
  output logic [15:0]   mem_din,
  input  logic [15:0]   mem_dout
);

  typedef enum logic [2:0] {
    IDLE,
    WR_HI,
    WR_LO,
    RD_HI,
    RD_LO,
    RD_FIN
  } state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [1:0]    be_lo;
  logic [15:0]   wdata_lo;
  logic [15:0]   rd_hi;

  assign req_ready = (state == IDLE);

  // SPRAM controls are registered one state ahead: the high half is launched
  // straight from the request inputs, so only the low half needs holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      be_lo      <= '0;
      wdata_lo   <= '0;
      rd_hi      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_we     <= '0;
      mem_din    <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= '0;
      mem_din    <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr     <= req_addr;
            be_lo    <= req_be[1:0];
            wdata_lo <= req_wdata[15:0];
            mem_addr <= {req_addr, 1'b0};
            if (req_we) begin
              state   <= WR_HI;
              mem_din <= req_wdata[31:16];
              mem_we  <= {req_be[3], req_be[3], req_be[2], req_be[2]};
            end else begin
              state <= RD_HI;
            end
          end
        end
        WR_HI: begin
          state    <= WR_LO;
          mem_addr <= {addr, 1'b1};
          mem_din  <= wdata_lo;
          mem_we   <= {be_lo[1], be_lo[1], be_lo[0], be_lo[0]};
        end
        WR_LO: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        RD_HI: begin
          state    <= RD_LO;
          mem_addr <= {addr, 1'b1};
        end
        RD_LO: begin
          state <= RD_FIN;
          rd_hi <= mem_dout;
        end
        RD_FIN: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          resp_rdata <= {rd_hi, mem_dout};
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_ctrl.sv
// Directed bench for spram_ctrl with a behavioural 16K x 16 nibble-masked SPRAM.
module tb_spram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [12:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [13:0] mem_addr;
  logic [3:0]  mem_we;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  logic [15:0] ram [0:16383];

  int checks = 0;
  int errors = 0;

  spram_ctrl #(.AW(13)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = '0;
    mem_dout = '0;
  end

  always @(posedge clk) begin
    for (int n = 0; n < 4; n++)
      if (mem_we[n]) ram[mem_addr][n*4 +: 4] <= mem_din[n*4 +: 4];
    mem_dout <= ram[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // All transaction tasks are entered and left at a falling edge.
  task automatic do_write(input string tag, input logic [12:0] a, input logic [3:0] be,
                          input logic [31:0] d, input logic [3:0] hwe, input logic [3:0] lwe);
    check({tag, " ready"}, 32'(req_ready), 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_be = be; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = ~a; req_be = ~be; req_wdata = ~d;
    check({tag, " busy"},    32'(req_ready), 0);
    check({tag, " hi_addr"}, 32'(mem_addr), 32'({a, 1'b0}));
    check({tag, " hi_din"},  32'(mem_din), 32'(d[31:16]));
    check({tag, " hi_we"},   32'(mem_we), 32'(hwe));
    @(posedge clk); #1;
    check({tag, " lo_addr"}, 32'(mem_addr), 32'({a, 1'b1}));
    check({tag, " lo_din"},  32'(mem_din), 32'(d[15:0]));
    check({tag, " lo_we"},   32'(mem_we), 32'(lwe));
    check({tag, " no_resp"}, 32'(resp_valid), 0);
    @(posedge clk); #1;
    check({tag, " resp"},    32'(resp_valid), 1);
    check({tag, " rdata0"},  resp_rdata, 0);
    check({tag, " idle_we"}, 32'(mem_we), 0);
    @(negedge clk);
  endtask

  task automatic do_read(input string tag, input logic [12:0] a, input logic [31:0] exp);
    check({tag, " ready"}, 32'(req_ready), 1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_be = 4'h0; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~a;
    check({tag, " hi_addr"}, 32'(mem_addr), 32'({a, 1'b0}));
    check({tag, " hi_we"},   32'(mem_we), 0);
    @(posedge clk); #1;
    check({tag, " lo_addr"}, 32'(mem_addr), 32'({a, 1'b1}));
    check({tag, " lo_we"},   32'(mem_we), 0);
    @(posedge clk); #1;
    check({tag, " fin_addr"}, 32'(mem_addr), 0);
    check({tag, " no_resp"},  32'(resp_valid), 0);
    @(posedge clk); #1;
    check({tag, " resp"},  32'(resp_valid), 1);
    check({tag, " rdata"}, resp_rdata, exp);
    @(negedge clk);
  endtask

  logic [12:0] b2b_addr [3];
  logic [31:0] b2b_data [3];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_be = '0; req_wdata = '0;
    #2;
    check("rst ready",    32'(req_ready), 1);
    check("rst resp",     32'(resp_valid), 0);
    check("rst rdata",    resp_rdata, 0);
    check("rst mem_we",   32'(mem_we), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst mem_din",  32'(mem_din), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    do_write("wr5", 13'h005, 4'hF, 32'hDEADBEEF, 4'hF, 4'hF);
    do_read ("rd5", 13'h005, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("resp pulse", 32'(resp_valid), 0);
    check("rdata hold", resp_rdata, 32'hDEADBEEF);
    @(negedge clk);

    do_write("be_full", 13'h020, 4'hF, 32'h11223344, 4'hF, 4'hF);
    do_write("be_0101", 13'h020, 4'b0101, 32'hAABBCCDD, 4'b0011, 4'b0011);
    do_read ("be_rd",   13'h020, 32'h11BB33DD);

    do_write("z_full", 13'h030, 4'hF, 32'h55667788, 4'hF, 4'hF);
    do_write("z_lo0",  13'h030, 4'b1100, 32'h99AABBCC, 4'hF, 4'h0);
    do_read ("z_rd",   13'h030, 32'h99AA7788);

    do_write("top_wr", 13'h1FFF, 4'hF, 32'hCAFEF00D, 4'hF, 4'hF);
    check("top hi half", 32'(ram[16382]), 32'h0000CAFE);
    check("top lo half", 32'(ram[16383]), 32'h0000F00D);
    do_read ("top_rd", 13'h1FFF, 32'hCAFEF00D);

    // Back-to-back reads with req_valid held high throughout.
    b2b_addr[0] = 13'h005;  b2b_data[0] = 32'hDEADBEEF;
    b2b_addr[1] = 13'h020;  b2b_data[1] = 32'h11BB33DD;
    b2b_addr[2] = 13'h1FFF; b2b_data[2] = 32'hCAFEF00D;
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0; req_addr = b2b_addr[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("b2b hi_addr", 32'(mem_addr), 32'({b2b_addr[i], 1'b0}));
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        check("b2b busy", 32'(req_ready), 0);
      end
      @(negedge clk);
      check("b2b ready", 32'(req_ready), 1);
      check("b2b resp",  32'(resp_valid), 1);
      check("b2b rdata", resp_rdata, b2b_data[i]);
      if (i < 2) req_addr = b2b_addr[i+1];
      else req_valid = 1'b0;
    end

    // Reset while the high half is being written.
    do_write("pre_rst", 13'h010, 4'hF, 32'h12345678, 4'hF, 4'hF);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 13'h010; req_be = 4'hF; req_wdata = 32'hAAAABBBB;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    check("abort in_wr_hi", 32'(mem_we), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    check("abort mem_we",   32'(mem_we), 0);
    check("abort mem_addr", 32'(mem_addr), 0);
    check("abort mem_din",  32'(mem_din), 0);
    check("abort ready",    32'(req_ready), 1);
    @(posedge clk); #1;
    check("abort no_resp",  32'(resp_valid), 0);
    check("abort we_hold",  32'(mem_we), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_read("abort_rd", 13'h010, 32'h12345678);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("idle no_resp", 32'(resp_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
